laser_line_timer: RTL and testbench

- Sits between the x-axis opto input (GPIO) and the y-axis row state machine / laser driver.
- Synchronises the asynchronous polygon-mirror opto strobe and rejects glitches, producing a clean one-cycle line strobe that the y-axis FSM consumes.
- Measures the mirror facet period and divides each line into equal pixel slots.
- Emits a column index and pixel strobe used to fetch framebuffer data and gate the laser.

---
 rtl/laser_line_timer.sv | 170 +++++++++++++++++
 tb/tb_laser_line_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/laser_line_timer.sv
`timescale 1ns/1ps
// Opto strobe conditioning and per-line pixel timing for the laser scanner: measures the
// mirror facet period, splits it into LINE_DIV slots and strobes the active columns.
module laser_line_timer #(
    parameter int NUM_COLS   = 320,
    parameter int LINE_DIV   = 400,
    parameter int H_OFFSET   = 40,
    parameter int PERIOD_W   = 20,
    parameter int MIN_PERIOD = 64,
    parameter int MAX_PERIOD = 2**20-1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                x_axis_stb,
    output logic                line_stb,
    output logic                locked,
    output logic                pix_stb,
    output logic [8:0]          pix_col,
    output logic                active,
    output logic [PERIOD_W-1:0] period
);
    localparam int SLOT_W = $clog2(LINE_DIV + 1);
    localparam int CNT_W  = $clog2(PERIOD_W + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OFFSET = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_TAIL   = 2'd3;

    localparam logic [PERIOD_W-1:0] MIN_GAP   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_GAP   = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W:0]   DIVISOR   = (PERIOD_W+1)'(LINE_DIV);
    localparam logic [SLOT_W-1:0]   SLOT_ACT  = SLOT_W'(H_OFFSET);
    localparam logic [SLOT_W-1:0]   SLOT_TAIL = SLOT_W'(H_OFFSET + NUM_COLS);
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(LINE_DIV - 1);

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (v >= MAX_GAP) ? MAX_GAP : v + PERIOD_W'(1);
    endfunction

    logic                sync_p0, sync_p1, sync_p2;
    logic                rise, accept, timeout, seen_edge;
    logic [PERIOD_W-1:0] gap_cnt;
    logic [PERIOD_W-1:0] pix_len_cur, pix_len_next;
    logic                len_cur_vld, len_next_vld;

    logic                div_busy;
    logic [CNT_W-1:0]    div_cnt;
    logic [PERIOD_W-1:0] div_rem, div_quo;
    logic [PERIOD_W:0]   div_trial;
    logic                div_ge;
    logic [PERIOD_W-1:0] div_rem_nxt, div_quo_nxt;

    logic [1:0]          state, state_nxt;
    logic [SLOT_W-1:0]   slot, slot_nxt;
    logic [PERIOD_W-1:0] sub, sub_nxt;
    logic                stb_nxt;
    logic [8:0]          col_nxt;

    // Stage p0/p1 resynchronise the opto input; p2 holds the previous level for edge detect
    assign rise    = sync_p1 & ~sync_p2;
    assign accept  = rise && (!seen_edge || gap_cnt >= MIN_GAP);
    assign timeout = (gap_cnt == MAX_GAP);
    assign locked  = len_cur_vld;
    assign active  = (state == ST_ACTIVE);

    // Restoring divider step: shift the next dividend bit into the remainder, subtract if it fits
    assign div_trial   = {div_rem, div_quo[PERIOD_W-1]};
    assign div_ge      = (div_trial >= DIVISOR);
    assign div_rem_nxt = div_ge ? PERIOD_W'(div_trial - DIVISOR) : PERIOD_W'(div_trial);
    assign div_quo_nxt = {div_quo[PERIOD_W-2:0], div_ge};

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        sub_nxt   = sub;
        if (accept) begin
            // An edge always restarts the line, aborting whatever was in progress
            state_nxt = len_next_vld ? ST_OFFSET : ST_IDLE;
            slot_nxt  = '0;
            sub_nxt   = '0;
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end else if (state != ST_IDLE) begin
            if (sub == pix_len_cur - PERIOD_W'(1)) begin
                sub_nxt = '0;
                if (slot != SLOT_LAST) slot_nxt = slot + SLOT_W'(1);
            end else begin
                sub_nxt = sub + PERIOD_W'(1);
            end
            if (state == ST_OFFSET && slot_nxt == SLOT_ACT) state_nxt = ST_ACTIVE;
            else if (state == ST_ACTIVE && slot_nxt == SLOT_TAIL) state_nxt = ST_TAIL;
        end
    end

    assign stb_nxt = (state_nxt == ST_ACTIVE) && (sub_nxt == '0);
    assign col_nxt = 9'(slot_nxt - SLOT_ACT);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            sync_p2     <= 1'b0;
            line_stb    <= 1'b0;
            seen_edge   <= 1'b0;
            gap_cnt     <= '0;
            period      <= '0;
            pix_len_cur <= '0;
            len_cur_vld <= 1'b0;
            state       <= ST_IDLE;
            slot        <= '0;
            sub         <= '0;
            pix_stb     <= 1'b0;
            pix_col     <= '0;
        end else begin
            sync_p0  <= x_axis_stb;
            sync_p1  <= sync_p0;
            sync_p2  <= sync_p1;
            line_stb <= accept;
            if (accept) begin
                gap_cnt     <= '0;
                period      <= sat_inc(gap_cnt);
                seen_edge   <= 1'b1;
                pix_len_cur <= pix_len_next;
                len_cur_vld <= len_next_vld;
            end else begin
                gap_cnt <= sat_inc(gap_cnt);
                if (timeout) begin
                    seen_edge   <= 1'b0;
                    len_cur_vld <= 1'b0;
                end
            end
            state   <= state_nxt;
            slot    <= slot_nxt;
            sub     <= sub_nxt;
            pix_stb <= stb_nxt;
            if (stb_nxt) pix_col <= col_nxt;
        end
    end

    // The first edge after reset or unlock has no valid period, so the divider waits for the next
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_busy     <= 1'b0;
            div_cnt      <= '0;
            div_rem      <= '0;
            div_quo      <= '0;
            pix_len_next <= '0;
            len_next_vld <= 1'b0;
        end else begin
            if (accept && seen_edge) begin
                div_busy <= 1'b1;
                div_cnt  <= CNT_W'(PERIOD_W);
                div_rem  <= '0;
                div_quo  <= sat_inc(gap_cnt);
            end else if (div_busy) begin
                div_rem <= div_rem_nxt;
                div_quo <= div_quo_nxt;
                div_cnt <= div_cnt - CNT_W'(1);
                if (div_cnt == CNT_W'(1)) begin
                    div_busy     <= 1'b0;
                    pix_len_next <= div_quo_nxt;
                    len_next_vld <= (div_quo_nxt != '0);
                end
            end
            if (timeout && !accept) len_next_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_laser_line_timer.sv
`timescale 1ns/1ps
// Directed bench for laser_line_timer: lock-up, glitch, early edge, speed change,
// timeout and mid-line reset, with per-line pixel statistics gathered by a monitor.
module tb_laser_line_timer;
    localparam int MAX_P = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_axis_stb;
    logic        line_stb, locked, pix_stb, active;
    logic [8:0]  pix_col;
    logic [19:0] period;

    typedef struct {
        longint line_t;
        longint first_dt;
        longint last_dt;
        longint act_last_dt;
        int     period;
        int     n_pix;
        int     first_col;
        int     last_col;
        int     seq_bad;
        logic   locked;
    } line_rec_t;

    line_rec_t lines[$];
    line_rec_t cur;
    bit        have_line = 1'b0;
    longint    rise_q[$];
    int        n_cmp = 0;
    int        n_mis = 0;

    laser_line_timer #(.MAX_PERIOD(MAX_P)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .x_axis_stb (x_axis_stb),
        .line_stb   (line_stb),
        .locked     (locked),
        .pix_stb    (pix_stb),
        .pix_col    (pix_col),
        .active     (active),
        .period     (period)
    );

    always #5 clk = ~clk;

    function automatic longint now_c();
        return longint'($time / 10);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input longint t);
        int guard = 0;
        while (now_c() < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (now_c() < t) chk("wait_bound", now_c(), t);
    endtask

    task automatic rise();
        x_axis_stb = 1'b1;
        rise_q.push_back(now_c());
        tick(8);
        x_axis_stb = 1'b0;
    endtask

    task automatic strobe(input int gap, input bit glitch);
        rise();
        if (glitch) begin
            tick(22);
            x_axis_stb = 1'b1;
            tick(2);
            x_axis_stb = 1'b0;
            tick(gap - 32);
        end else begin
            tick(gap - 8);
        end
    endtask

    function automatic line_rec_t ln(input int i);
        line_rec_t r;
        r = '{default: 0};
        if (i < lines.size()) r = lines[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (line_stb) begin
            if (have_line) lines.push_back(cur);
            cur = '{default: 0};
            cur.line_t    = now_c();
            cur.locked    = locked;
            cur.period    = int'(period);
            cur.first_col = -1;
            cur.last_col  = -1;
            have_line     = 1'b1;
        end
        if (pix_stb && have_line) begin
            if (cur.n_pix == 0) begin
                cur.first_dt  = now_c() - cur.line_t;
                cur.first_col = int'(pix_col);
                if (pix_col != 9'd0) cur.seq_bad++;
            end else if (int'(pix_col) != cur.last_col + 1) begin
                cur.seq_bad++;
            end
            cur.last_dt  = now_c() - cur.line_t;
            cur.last_col = int'(pix_col);
            cur.n_pix++;
        end
        if (active && have_line) cur.act_last_dt = now_c() - cur.line_t;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_rec_t r;
        longint    t11, t14;
        reset      = 1'b1;
        x_axis_stb = 1'b0;
        tick(5);
        chk("rst_line_stb", line_stb, 0);
        chk("rst_locked",   locked,   0);
        chk("rst_pix_stb",  pix_stb,  0);
        chk("rst_pix_col",  pix_col,  0);
        chk("rst_active",   active,   0);
        chk("rst_period",   period,   0);
        reset = 1'b0;
        tick(100);

        for (int i = 0; i < 5; i++) strobe(4000, i == 3);
        strobe(2000, 1'b0);
        strobe(4000, 1'b0);
        strobe(4000, 1'b0);
        for (int i = 0; i < 3; i++) strobe(3600, 1'b0);

        rise();
        t11 = cur.line_t;
        chk("latency_s11", t11 - rise_q[11], 3);
        wait_until(t11 + MAX_P);
        chk("locked_before_timeout", locked, 1);
        tick(1);
        chk("locked_after_timeout", locked, 0);
        chk("active_after_timeout", active, 0);
        wait_until(rise_q[11] + 7000);

        strobe(4000, 1'b0);
        strobe(4000, 1'b0);
        rise();
        t14 = cur.line_t;
        wait_until(t14 + 1400);
        chk("s14_pix_stb_col100", pix_stb, 1);
        chk("s14_pix_col",        pix_col, 100);
        chk("s14_active",         active,  1);
        reset = 1'b1;
        tick(1);
        chk("midrst_line_stb", line_stb, 0);
        chk("midrst_locked",   locked,   0);
        chk("midrst_pix_stb",  pix_stb,  0);
        chk("midrst_pix_col",  pix_col,  0);
        chk("midrst_active",   active,   0);
        chk("midrst_period",   period,   0);
        reset = 1'b0;
        wait_until(rise_q[14] + 4000);
        strobe(4000, 1'b0);
        strobe(4000, 1'b0);
        chk("l16_locked", cur.locked, 0);
        chk("locked_end", locked, 0);

        chk("line_count", lines.size(), 16);
        r = ln(0);  chk("latency_s0", r.line_t - rise_q[0], 3);
        r = ln(1);  chk("l1_locked", r.locked, 0);
                    chk("l1_period", r.period, 4000);
        r = ln(2);  chk("l2_locked", r.locked, 1);
                    chk("l2_first_dt", r.first_dt, 400);
                    chk("l2_first_col", r.first_col, 0);
                    chk("l2_last_dt", r.last_dt, 3590);
                    chk("l2_last_col", r.last_col, 319);
                    chk("l2_n_pix", r.n_pix, 320);
                    chk("l2_seq_bad", r.seq_bad, 0);
                    chk("l2_active_last", r.act_last_dt, 3599);
        r = ln(3);  chk("l3_period", r.period, 4000);
                    chk("glitch_l3_n_pix", r.n_pix, 320);
                    chk("glitch_l3_first_dt", r.first_dt, 400);
                    chk("glitch_l3_seq_bad", r.seq_bad, 0);
        r = ln(4);  chk("glitch_l4_period", r.period, 4000);
                    chk("glitch_l4_gap", r.line_t - ln(3).line_t, 4000);
        r = ln(5);  chk("early_l5_n_pix", r.n_pix, 160);
                    chk("early_l5_last_col", r.last_col, 159);
                    chk("early_l5_last_dt", r.last_dt, 1990);
        r = ln(6);  chk("early_l6_first_dt", r.first_dt, 400);
                    chk("early_l6_first_col", r.first_col, 0);
                    chk("early_l6_period", r.period, 2000);
        r = ln(9);  chk("speed_l9_period", r.period, 3600);
                    chk("speed_l9_last_dt", r.last_dt, 3590);
                    chk("speed_l9_n_pix", r.n_pix, 320);
        r = ln(10); chk("speed_l10_first_dt", r.first_dt, 360);
                    chk("speed_l10_last_dt", r.last_dt, 3231);
                    chk("speed_l10_n_pix", r.n_pix, 320);
                    chk("speed_l10_last_col", r.last_col, 319);
        r = ln(12); chk("relock_l12_locked", r.locked, 0);
        r = ln(13); chk("relock_l13_locked", r.locked, 0);
                    chk("relock_l13_period", r.period, 4000);
        r = ln(14); chk("relock_l14_locked", r.locked, 1);
                    chk("relock_l14_first_dt", r.first_dt, 400);
        r = ln(15); chk("postrst_l15_locked", r.locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
